// File: rtl/result_digit_pkg.sv
// Shared types and constants for the result-to-digit display block.
package result_digit_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic MODE_HEX = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int MAX_DIGITS = 8;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/result_digit_display_dabble.sv
// One double-dabble iteration: add-3 adjust on every BCD nibble, then shift in one bit.
module bcd_dabble_step
  import result_digit_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic                    shift_in,
  output logic [4*NUM_DIGITS-1:0] bcd_next,
  output logic                    carry
);

  logic [4*NUM_DIGITS-1:0] adj;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    assign adj[4*g +: 4] = (bcd[4*g +: 4] >= BCD_ADJ_THRESH) ?
                           bcd[4*g +: 4] + BCD_ADJ_ADD : bcd[4*g +: 4];
  end

  // Bit leaving the top nibble is the overflow into a digit we do not keep.
  assign {carry, bcd_next} = {adj, shift_in};

endmodule

// File: rtl/result_digit_display.sv
// Halt-time result capture: hex nibble slice or sequential double-dabble to NUM_DIGITS digits.
// Optional leading-zero blank mask enabled by defining LEADING_ZERO_BLANK_EN.
module result_digit_display
  import result_digit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hlt,
  input  logic                    mode,
  input  logic [DATA_W-1:0]       Result,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    valid,
  output logic                    busy,
  output logic                    overflow,
  output logic [NUM_DIGITS-1:0]   blank
);

  localparam int BCD_W = 4*NUM_DIGITS;

  state_t              state;
  logic                hlt_q, pending, mode_q, sticky;
  logic [DATA_W-1:0]   res_q, sh;
  logic [BCD_W-1:0]    bcd, bcd_next, digits_d;
  logic                carry, hex_ovf, trigger, last_shift, done;
  logic [CNT_W-1:0]    cnt;

  bcd_dabble_step #(.NUM_DIGITS(NUM_DIGITS)) u_step (
    .bcd      (bcd),
    .shift_in (sh[DATA_W-1]),
    .bcd_next (bcd_next),
    .carry    (carry)
  );

  if (BCD_W < DATA_W) begin : g_hex_ovf
    assign hex_ovf = |sh[DATA_W-1:BCD_W];
  end else begin : g_no_hex_ovf
    assign hex_ovf = 1'b0;
  end

  // pending covers a Result that changed and changed back mid-conversion.
  assign trigger    = hlt && (!hlt_q || (Result != res_q) || pending);
  assign last_shift = (cnt == CNT_W'(DATA_W-1));
  assign done       = (state == CONV) && hlt && ((mode_q == MODE_HEX) || last_shift);
  assign digits_d   = (mode_q == MODE_DEC) ? bcd_next : sh[BCD_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hlt_q    <= 1'b0;
      res_q    <= '0;
      pending  <= 1'b0;
      mode_q   <= MODE_HEX;
      sticky   <= 1'b0;
      sh       <= '0;
      bcd      <= '0;
      cnt      <= '0;
      digits   <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      hlt_q <= hlt;
      if (!hlt) begin
        state    <= IDLE;
        pending  <= 1'b0;
        digits   <= '0;
        valid    <= 1'b0;
        busy     <= 1'b0;
        overflow <= 1'b0;
      end else begin
        case (state)
          IDLE: if (trigger) begin
            sh      <= Result;
            res_q   <= Result;
            mode_q  <= mode;
            cnt     <= '0;
            bcd     <= '0;
            sticky  <= 1'b0;
            pending <= 1'b0;
            busy    <= 1'b1;
            state   <= CONV;
          end
          CONV: begin
            if (Result != res_q) pending <= 1'b1;
            if (done) begin
              digits   <= digits_d;
              overflow <= (mode_q == MODE_HEX) ? hex_ovf : (sticky | carry);
              valid    <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              bcd    <= bcd_next;
              sh     <= sh << 1;
              sticky <= sticky | carry;
              cnt    <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_d;

  // Digit i blanks only if it and every more significant digit are zero.
  always_comb begin
    logic zero_above;
    blank_d    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 1; i--) begin
      zero_above = zero_above && (digits_d[4*i +: 4] == 4'd0);
      blank_d[i] = zero_above;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    blank <= '0;
    else if (!hlt) blank <= '0;
    else if (done) blank <= blank_d;
  end
`else
  assign blank = '0;
`endif

endmodule
